// File: rtl/vram_arbiter.sv
// Video-RAM arbiter: display fetches, buffered CPU writes and CPU reads share one synchronous RAM port.
// Optional VRAM_WR_FWD_EN forwards a CPU write to the currently displayed word straight into vgad_data.
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 15,
  parameter int DW         = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic [AW-1:0] vgad_addr,
  output logic [DW-1:0] vgad_data,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          cpu_busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  // grant     | meaning
  // G_IDLE    | no access, ram_addr holds
  // G_DISP    | display fetch of vgad_addr
  // G_CPU_RD  | CPU read of latched address (write FIFO empty)
  // G_CPU_WR  | drain FIFO head into RAM
  typedef enum logic [1:0] {G_IDLE, G_DISP, G_CPU_RD, G_CPU_WR} grant_t;

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          read_pending;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] last_addr;
  logic          disp_tag_valid;
  logic [1:0]    rd_tag;
  logic [AW-1:0] ram_addr_q;

  grant_t grant;
  logic   fifo_empty, fifo_full, push, pop, disp_req;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_FULL);
  assign cpu_busy   = fifo_full | read_pending;
  assign push       = enable & ~cpu_busy & cpu_we;
  assign pop        = (grant == G_CPU_WR);
  assign disp_req   = ~disp_tag_valid | (vgad_addr != last_addr);

  always_comb begin
    grant     = G_IDLE;
    ram_addr  = ram_addr_q;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (reset) begin
      ram_addr = '0;
    end else if (enable) begin
      // rd_tag[0] keeps a read in flight from being issued twice
      if (disp_req)
        grant = G_DISP;
      else if (read_pending && fifo_empty && !rd_tag[0])
        grant = G_CPU_RD;
      else if (!fifo_empty)
        grant = G_CPU_WR;
    end
    case (grant)
      G_DISP:   ram_addr = vgad_addr;
      G_CPU_RD: ram_addr = rd_addr;
      G_CPU_WR: begin
        ram_addr  = fifo_addr[rd_ptr];
        ram_wdata = fifo_data[rd_ptr];
        ram_we    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef VRAM_WR_FWD_EN
  logic fwd_hit;
  assign fwd_hit = pop && disp_tag_valid && (fifo_addr[rd_ptr] == last_addr);
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cpu_addr;
      fifo_data[wr_ptr] <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      read_pending   <= 1'b0;
      rd_addr        <= '0;
      last_addr      <= '0;
      disp_tag_valid <= 1'b0;
      rd_tag         <= '0;
      ram_addr_q     <= '0;
      vgad_data      <= '0;
      cpu_rdata      <= '0;
      cpu_rvalid     <= 1'b0;
    end else begin
      ram_addr_q <= ram_addr;
      rd_tag     <= {grant == G_DISP, grant == G_CPU_RD};
      cpu_rvalid <= rd_tag[0];
      if (rd_tag[1])
        vgad_data <= ram_rdata;
`ifdef VRAM_WR_FWD_EN
      else if (fwd_hit)
        vgad_data <= ram_wdata;
`endif
      if (rd_tag[0]) begin
        cpu_rdata    <= ram_rdata;
        read_pending <= 1'b0;
      end
      if (enable && !cpu_busy && cpu_re) begin
        read_pending <= 1'b1;
        rd_addr      <= cpu_addr;
      end
      if (grant == G_DISP) begin
        last_addr      <= vgad_addr;
        disp_tag_valid <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: RAM model, write/read scoreboards, display latency and reset checks.
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        reset, enable;
  logic [14:0] vgad_addr, cpu_addr, ram_addr;
  logic [15:0] vgad_data, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic        cpu_we, cpu_re, cpu_rvalid, cpu_busy, ram_we;

  int n_chk = 0;
  int n_pass = 0;
  bit [15:0]   mem [0:32767];
  logic [31:0] wq [$];
  logic [15:0] rq [$];

  vram_arbiter dut (
    .clk(clk), .reset(reset), .enable(enable),
    .vgad_addr(vgad_addr), .vgad_data(vgad_data),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .cpu_busy(cpu_busy),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ram_we) begin
        chk("wr_expected", {31'b0, wq.size() > 0}, 32'd1);
        if (wq.size() > 0) chk("wr_order", {1'b0, ram_addr, ram_wdata}, wq.pop_front());
      end
      if (cpu_rvalid) begin
        chk("rvalid_expected", {31'b0, rq.size() > 0}, 32'd1);
        if (rq.size() > 0) chk("rdata", cpu_rdata, rq.pop_front());
      end
      if ((cpu_we || cpu_re) && cpu_busy) chk("req_while_busy", 32'd1, {31'b0, !cpu_busy});
    end
  end

  initial begin
    int nw;
    int k;
    reset = 1'b1; enable = 1'b1; vgad_addr = '0;
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem[0] = 16'hA5A5;
    mem[15'h30] = 16'h7777;
    for (int i = 0; i < 16; i++) mem[15'h200 + 15'(i)] = 16'h5000 + 16'(i);

    // reset state and first display fetch
    step(); step();
    @(negedge clk);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_vgad_data", vgad_data, 0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_busy", cpu_busy, 0);
    step(); reset = 1'b0;
    @(negedge clk);
    chk("disp_first_addr", ram_addr, 0);
    chk("disp_first_we", ram_we, 0);
    step();
    @(negedge clk);
    chk("disp_lat1", vgad_data, 0);
    step();
    chk("disp_lat2", vgad_data, 16'hA5A5);

    // fill the FIFO while the display takes every slot
    for (int i = 0; i < 4; i++) begin
      vgad_addr = 15'h100 + 15'(i);
      cpu_we = 1'b1; cpu_addr = 15'h10 + 15'(i); cpu_wdata = 16'h1000 + 16'(i);
      wq.push_back({1'b0, cpu_addr, cpu_wdata});
      step();
    end
    cpu_we = 1'b0;
    @(negedge clk);
    chk("busy_full", cpu_busy, 1);
    step();
    for (k = 0; k < 20 && cpu_busy; k++) step();
    chk("busy_release", cpu_busy, 0);
    cpu_we = 1'b1; cpu_addr = 15'h14; cpu_wdata = 16'h1004;
    wq.push_back({1'b0, cpu_addr, cpu_wdata});
    step(); cpu_we = 1'b0;
    for (k = 0; k < 30 && wq.size() != 0; k++) step();
    chk("wq_drain1", wq.size(), 0);
    step();
    for (int i = 0; i < 5; i++) chk("ram_content1", mem[15'h10 + 15'(i)], 16'h1000 + 16'(i));

    // write then read of the same address in one cycle
    cpu_we = 1'b1; cpu_re = 1'b1; cpu_addr = 15'h20; cpu_wdata = 16'hBEEF;
    wq.push_back({1'b0, 15'h20, 16'hBEEF});
    rq.push_back(16'hBEEF);
    step(); cpu_we = 1'b0; cpu_re = 1'b0;
    for (k = 0; k < 20 && rq.size() != 0; k++) step();
    chk("raw_drain", rq.size() + wq.size(), 0);

    // read latency with empty FIFO
    step();
    cpu_re = 1'b1; cpu_addr = 15'h11;
    rq.push_back(16'h1001);
    step(); cpu_re = 1'b0;
    chk("rd_lat_busy", cpu_busy, 1);
    chk("rd_lat_t0", cpu_rvalid, 0);
    step();
    chk("rd_lat_t1", cpu_rvalid, 0);
    step();
    chk("rd_lat_t2", cpu_rvalid, 1);
    chk("rd_lat_unbusy", cpu_busy, 0);
    step();

    // display changing every 2 cycles while CPU writes 8 words
    nw = 0;
    for (int j = 0; j < 12; j++) begin
      vgad_addr = 15'h200 + 15'(j);
      for (int c = 0; c < 2; c++) begin
        cpu_we = (nw < 8) && !cpu_busy;
        cpu_addr = 15'h40 + 15'(nw); cpu_wdata = 16'h4000 + 16'(nw);
        if (cpu_we) wq.push_back({1'b0, cpu_addr, cpu_wdata});
        if (c == 0) begin
          @(negedge clk);
          chk("toggle_grant", {ram_we, ram_addr}, {1'b0, vgad_addr});
        end
        step();
        if (cpu_we) nw++;
      end
      chk("toggle_vgad", vgad_data, 16'h5000 + 16'(j));
    end
    cpu_we = 1'b0;
    for (k = 0; k < 30 && wq.size() != 0; k++) step();
    chk("wq_drain2", wq.size(), 0);
    step();
    for (int i = 0; i < 8; i++) chk("ram_content2", mem[15'h40 + 15'(i)], 16'h4000 + 16'(i));

    // reset with writes queued and a read pending
    for (int i = 0; i < 3; i++) begin
      vgad_addr = 15'h300 + 15'(i);
      cpu_we = 1'b1; cpu_addr = 15'h60 + 15'(i); cpu_wdata = 16'h6000 + 16'(i);
      step();
    end
    cpu_we = 1'b0;
    vgad_addr = 15'h303; cpu_re = 1'b1; cpu_addr = 15'h60;
    step();
    cpu_re = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_we", ram_we, 0);
    step(); reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", cpu_busy, 0);
    chk("rst_mid_rvalid", cpu_rvalid, 0);
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 3; i++) chk("rst_mid_ram", mem[15'h60 + 15'(i)], 0);

    // write to the displayed word
    vgad_addr = 15'h30;
    step(); step(); step();
    chk("fwd_pre", vgad_data, 16'h7777);
    cpu_we = 1'b1; cpu_addr = 15'h30; cpu_wdata = 16'h1234;
    wq.push_back({1'b0, 15'h30, 16'h1234});
    step(); cpu_we = 1'b0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ram_we) break;
      step();
    end
    chk("fwd_we_seen", {31'b0, k < 10}, 1);
    step();
`ifdef VRAM_WR_FWD_EN
    chk("fwd_vgad", vgad_data, 16'h1234);
`else
    chk("fwd_vgad", vgad_data, 16'h7777);
`endif
    step(); step();
    chk("final_queues", wq.size() + rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
